cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//   Run/halt/single-step sequencer for the uCISC cpu core. Sits between the board clock and the cpu.
//   Emits a one-cycle clock-enable tick at a programmable rate, halts on request or on a PC breakpoint,
//   and single-steps exactly one instruction. Replaces the fixed free-running slow_clock divider in top.
// PARAMETERS
//   DIV_WIDTH   25    width of tick prescaler counter and div_limit port
//   STEP_LAST   2'd3  cpu step value in which an instruction completes
//   RESET_RUN   1     1: state after reset is RUN; 0: HALT
// PORTS
//   clock_input  in   1          single system clock; all logic on posedge
//   reset        in   1          synchronous, active-high
//   div_limit    in   DIV_WIDTH  tick period minus 1 (0 = tick every enabled cycle)
//   run_req      in   1          level/pulse: enter RUN
//   halt_req     in   1          level/pulse: enter HALT
//   step_req     in   1          pulse: execute one instruction from HALT/BREAK
//   bp_enable    in   1          breakpoint compare enable
//   bp_addr      in   16         breakpoint PC
//   cpu_pc       in   16         cpu pc_peek
//   cpu_step     in   2          cpu step (instruction stage)
//   cpu_tick     out  1          registered clock enable to cpu, one cycle wide
//   halted       out  1          1 in HALT or BREAK
//   bp_hit       out  1          1 while in BREAK
//   state        out  2          0 HALT, 1 RUN, 2 STEP, 3 BREAK
//   instr_count  out  16         instructions completed since reset, wraps
// BEHAVIOUR
//   Reset: state=RUN if RESET_RUN else HALT; prescaler=0; cpu_tick=0; bp_hit=0; bp_skip=0;
//     instr_count=0; halted=!RESET_RUN. All outputs registered; request at edge N acts at edge N+1.
//   Prescaler: counts only in RUN/STEP; at div_limit -> cpu_tick=1 next cycle, counter to 0;
//     otherwise increments, cpu_tick=0. Held at 0 in HALT/BREAK. div_limit change takes effect on
//     next compare; if counter > new div_limit, counter wraps through 2^DIV_WIDTH (no clamping).
//   Boundary = tick issued while cpu_step==STEP_LAST; instr_count += 1 on each boundary tick.
//   Breakpoint: in RUN, when a tick is due and bp_enable && cpu_pc==bp_addr && cpu_step==0 && !bp_skip
//     -> tick suppressed, state->BREAK, bp_hit=1. bp_skip set on leaving BREAK/HALT, cleared on the
//     first boundary tick, so resume executes the breakpointed instruction once.
//   Transitions (priority halt_req > run_req > step_req, evaluated every cycle):
//     HALT/BREAK: halt_req -> HALT; run_req -> RUN; step_req -> STEP; else hold.
//     RUN:  halt_req -> HALT (tick due same cycle is suppressed); bp match -> BREAK.
//     STEP: halt_req -> HALT; boundary tick -> HALT. run_req in STEP -> RUN (no instr lost).
//     Breakpoint not checked in STEP (step over a breakpoint always succeeds).
//   Leaving BREAK clears bp_hit. step_req in RUN/STEP ignored.
//   Reset mid-instruction: controller returns to reset state; cpu resets from same reset.
//   instr_count wraps 16'hFFFF -> 0.
// TESTING
//   reset, RESET_RUN=1, div_limit=3 -> cpu_tick high 1 of every 4 cycles; first tick 4 cycles after reset release
//   div_limit=0, run -> cpu_tick=1 every cycle; 8 ticks with step cycling 0..3 -> instr_count=2
//   halt_req in RUN, then step_req with cpu_step=0 -> exactly 4 ticks, state back to HALT, instr_count +1
//   bp_enable=1, bp_addr=16'h0010, pc reaches 0x0010 at step 0 -> no tick, state=3, bp_hit=1;
//     run_req -> instr at 0x0010 executes once, no re-break
//   halt_req and run_req same cycle in HALT -> stays HALT; step_req+run_req in HALT -> RUN
//   reset asserted during STEP with prescaler mid-count -> next cycle cpu_tick=0, prescaler=0, instr_count=0

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the uCISC cpu: issues a programmable-rate clock-enable
// tick, stops on request or on a PC breakpoint, and single-steps one instruction at a time.
module cpu_run_ctrl #(
    parameter int          DIV_WIDTH = 25,
    parameter logic [1:0]  STEP_LAST = 2'd3,
    parameter bit          RESET_RUN = 1'b1
) (
    input  logic                 clock_input,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] div_limit,
    input  logic                 run_req,
    input  logic                 halt_req,
    input  logic                 step_req,
    input  logic                 bp_enable,
    input  logic [15:0]          bp_addr,
    input  logic [15:0]          cpu_pc,
    input  logic [1:0]           cpu_step,
    output logic                 cpu_tick,
    output logic                 halted,
    output logic                 bp_hit,
    output logic [1:0]           state,
    output logic [15:0]          instr_count
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    localparam state_t RST_STATE = RESET_RUN ? ST_RUN : ST_HALT;

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   presc_q, presc_d;
    logic                   tick_q, tick_d;
    logic                   bp_hit_q, bp_hit_d;
    logic                   bp_skip_q, bp_skip_d;
    logic                   halted_q, halted_d;
    logic [15:0]            instr_count_q, instr_count_d;

    logic active, stopped_q, stopped_d, tick_due, bp_match, boundary;

    always_comb begin
        state_d       = state_q;
        presc_d       = '0;
        tick_d        = 1'b0;
        bp_skip_d     = bp_skip_q;
        instr_count_d = instr_count_q;

        active    = (state_q == ST_RUN) || (state_q == ST_STEP);
        stopped_q = (state_q == ST_HALT) || (state_q == ST_BREAK);
        tick_due  = active && (presc_q == div_limit);
        bp_match  = (state_q == ST_RUN) && tick_due && bp_enable &&
                    (cpu_pc == bp_addr) && (cpu_step == 2'd0) && !bp_skip_q;

        case (state_q)
            ST_HALT, ST_BREAK: begin
                if (halt_req)      state_d = ST_HALT;
                else if (run_req)  state_d = ST_RUN;
                else if (step_req) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (halt_req)      state_d = ST_HALT;
                else if (bp_match) state_d = ST_BREAK;
            end
            ST_STEP: begin
                if (halt_req)     state_d = ST_HALT;
                else if (run_req) state_d = ST_RUN;
                else if (tick_due && (cpu_step == STEP_LAST)) state_d = ST_HALT;
            end
            default: state_d = RST_STATE;
        endcase

        // A halt request or a breakpoint hit swallows the tick that was due this cycle.
        tick_d    = tick_due && !halt_req && !bp_match;
        boundary  = tick_d && (cpu_step == STEP_LAST);
        stopped_d = (state_d == ST_HALT) || (state_d == ST_BREAK);

        if (active && !stopped_d)
            presc_d = tick_due ? '0 : presc_q + DIV_WIDTH'(1);

        // Resuming must let the instruction sitting on the breakpoint run once.
        if (stopped_q && !stopped_d)
            bp_skip_d = 1'b1;
        else if (boundary)
            bp_skip_d = 1'b0;

        if (boundary)
            instr_count_d = instr_count_q + 16'd1;

        bp_hit_d = (state_d == ST_BREAK);
        halted_d = stopped_d;
    end

    always_ff @(posedge clock_input) begin
        if (reset) begin
            state_q       <= RST_STATE;
            presc_q       <= '0;
            tick_q        <= 1'b0;
            bp_hit_q      <= 1'b0;
            bp_skip_q     <= 1'b0;
            halted_q      <= !RESET_RUN;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            tick_q        <= tick_d;
            bp_hit_q      <= bp_hit_d;
            bp_skip_q     <= bp_skip_d;
            halted_q      <= halted_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cpu_tick    = tick_q;
    assign halted      = halted_q;
    assign bp_hit      = bp_hit_q;
    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a tiny cpu model advances cpu_step (and optionally pc) on each tick.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] div_limit;
    logic        run_req, halt_req, step_req, bp_enable;
    logic [15:0] bp_addr, cpu_pc;
    logic [1:0]  cpu_step;
    logic        cpu_tick, halted, bp_hit;
    logic [1:0]  state;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_cnt = 0;
    bit auto_step = 1'b0;
    bit pc_adv = 1'b0;

    cpu_run_ctrl #(.DIV_WIDTH(25), .STEP_LAST(2'd3), .RESET_RUN(1'b1)) dut (
        .clock_input(clk),
        .reset(reset),
        .div_limit(div_limit),
        .run_req(run_req),
        .halt_req(halt_req),
        .step_req(step_req),
        .bp_enable(bp_enable),
        .bp_addr(bp_addr),
        .cpu_pc(cpu_pc),
        .cpu_step(cpu_step),
        .cpu_tick(cpu_tick),
        .halted(halted),
        .bp_hit(bp_hit),
        .state(state),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // One clock; the cpu model reacts to a tick as the cpu would before the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (cpu_tick) begin
            tick_cnt++;
            if (auto_step) begin
                if (cpu_step == 2'd3 && pc_adv) cpu_pc = cpu_pc + 16'd1;
                cpu_step = cpu_step + 2'd1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; div_limit = 25'd3; cpu_step = 2'd0; auto_step = 1'b0;
        cyc(); cyc();
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL reset_state: got %0d want 1", state); end
        n_cmp++; if (cpu_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", cpu_tick); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (bp_hit !== 1'b0) begin n_bad++; $display("FAIL reset_bp_hit: got %b want 0", bp_hit); end
        n_cmp++; if (instr_count !== 16'd0) begin n_bad++; $display("FAIL reset_icount: got %0d want 0", instr_count); end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            n_cmp++;
            if (cpu_tick !== ((k % 4) == 0)) begin
                n_bad++; $display("FAIL div3_tick cycle %0d: got %b want %b", k, cpu_tick, (k % 4) == 0);
            end
        end
    endtask

    task automatic test_run_fast();
        reset = 1'b1; div_limit = 25'd0; cpu_step = 2'd0; auto_step = 1'b1; pc_adv = 1'b0;
        cyc();
        reset = 1'b0; tick_cnt = 0;
        repeat (8) cyc();
        n_cmp++; if (tick_cnt != 8) begin n_bad++; $display("FAIL run_ticks: got %0d want 8", tick_cnt); end
        n_cmp++; if (instr_count !== 16'd2) begin n_bad++; $display("FAIL run_icount: got %0d want 2", instr_count); end
    endtask

    task automatic test_halt_step();
        halt_req = 1'b1; cyc(); halt_req = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL halt_state: got %0d want 0", state); end
        n_cmp++; if (cpu_tick !== 1'b0) begin n_bad++; $display("FAIL halt_tick: got %b want 0", cpu_tick); end
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_halted: got %b want 1", halted); end
        n_cmp++; if (instr_count !== 16'd2) begin n_bad++; $display("FAIL halt_icount: got %0d want 2", instr_count); end
        tick_cnt = 0;
        step_req = 1'b1; cyc(); step_req = 1'b0;
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL step_state: got %0d want 2", state); end
        repeat (5) cyc();
        n_cmp++; if (tick_cnt != 4) begin n_bad++; $display("FAIL step_ticks: got %0d want 4", tick_cnt); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL step_end_state: got %0d want 0", state); end
        n_cmp++; if (instr_count !== 16'd3) begin n_bad++; $display("FAIL step_icount: got %0d want 3", instr_count); end
    endtask

    task automatic test_breakpoint();
        reset = 1'b1; div_limit = 25'd0; cpu_pc = 16'h0010; cpu_step = 2'd0;
        bp_enable = 1'b1; bp_addr = 16'h0010; auto_step = 1'b1; pc_adv = 1'b1;
        cyc();
        reset = 1'b0; tick_cnt = 0;
        cyc();
        n_cmp++; if (cpu_tick !== 1'b0) begin n_bad++; $display("FAIL bp_tick: got %b want 0", cpu_tick); end
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL bp_state: got %0d want 3", state); end
        n_cmp++; if (bp_hit !== 1'b1) begin n_bad++; $display("FAIL bp_hit: got %b want 1", bp_hit); end
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL bp_halted: got %b want 1", halted); end
        cyc();
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL bp_hold: got %0d want 3", state); end
        run_req = 1'b1; cyc(); run_req = 1'b0;
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL bp_resume_state: got %0d want 1", state); end
        n_cmp++; if (bp_hit !== 1'b0) begin n_bad++; $display("FAIL bp_resume_hit: got %b want 0", bp_hit); end
        repeat (5) cyc();
        n_cmp++; if (tick_cnt != 5) begin n_bad++; $display("FAIL bp_resume_ticks: got %0d want 5", tick_cnt); end
        n_cmp++; if (instr_count !== 16'd1) begin n_bad++; $display("FAIL bp_icount: got %0d want 1", instr_count); end
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL bp_no_rebreak: got %0d want 1", state); end
        auto_step = 1'b0; pc_adv = 1'b0; bp_enable = 1'b0; cpu_step = 2'd0;
    endtask

    task automatic test_priority();
        halt_req = 1'b1; cyc(); halt_req = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL prio_halt: got %0d want 0", state); end
        halt_req = 1'b1; run_req = 1'b1; cyc(); halt_req = 1'b0; run_req = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL prio_halt_over_run: got %0d want 0", state); end
        step_req = 1'b1; run_req = 1'b1; cyc(); step_req = 1'b0; run_req = 1'b0;
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL prio_run_over_step: got %0d want 1", state); end
    endtask

    task automatic test_reset_mid_step();
        halt_req = 1'b1; cyc(); halt_req = 1'b0;
        div_limit = 25'd5; cpu_step = 2'd0;
        step_req = 1'b1; cyc(); step_req = 1'b0;
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL mid_step_state: got %0d want 2", state); end
        cyc(); cyc();
        n_cmp++; if (cpu_tick !== 1'b0) begin n_bad++; $display("FAIL mid_step_tick: got %b want 0", cpu_tick); end
        reset = 1'b1; cyc(); reset = 1'b0;
        n_cmp++; if (cpu_tick !== 1'b0) begin n_bad++; $display("FAIL rst_step_tick: got %b want 0", cpu_tick); end
        n_cmp++; if (instr_count !== 16'd0) begin n_bad++; $display("FAIL rst_step_icount: got %0d want 0", instr_count); end
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL rst_step_state: got %0d want 1", state); end
        for (int k = 1; k <= 6; k++) begin
            cyc();
            n_cmp++;
            if (cpu_tick !== (k == 6)) begin
                n_bad++; $display("FAIL rst_step_presc cycle %0d: got %b want %b", k, cpu_tick, k == 6);
            end
        end
    endtask

    initial begin
        reset = 1'b1; div_limit = '0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        bp_enable = 1'b0; bp_addr = 16'h0000; cpu_pc = 16'h0000; cpu_step = 2'd0;
        test_reset();
        test_run_fast();
        test_halt_step();
        test_breakpoint();
        test_priority();
        test_reset_mid_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
